// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: opcodes, aluOp / aluSrcB / pcSource encodings, the main control
// state enum and the bundled control-signal struct. The ADDI states exist only
// when MAIN_CONTROL_ADDI_EN is defined.
package mips_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // aluOp codes consumed by alu_control
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // ALU operand-B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
`ifdef MAIN_CONTROL_ADDI_EN
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
`else
    ST_JUMP      = 4'd9
`endif
  } ctrl_state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_sig_t;

  // True for every opcode the control unit can sequence in this build.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ)   || (op == OP_J);
`ifdef MAIN_CONTROL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Maps the main control state to the full set of datapath control signals.
// Latency: purely combinational.
// Backpressure: mem_ready_i only gates irWrite/pcWrite in FETCH.
// Ports: state_i (current state), mem_ready_i (ready, already reset-gated),
//        sig_o (bundled controls). Optional: MAIN_CONTROL_ADDI_EN.
import mips_pkg::*;

module main_control_decode (
  input  ctrl_state_t state_i,
  input  logic        mem_ready_i,
  output ctrl_sig_t   sig_o
);

  always_comb begin
    sig_o = '0;
    unique case (state_i)
      ST_FETCH: begin
        sig_o.mem_read  = 1'b1;
        sig_o.alu_src_b = SRCB_FOUR;
        sig_o.alu_op    = ALUOP_MEM;
        // Only Mealy terms: latch IR and advance PC on the cycle memory completes.
        sig_o.ir_write  = mem_ready_i;
        sig_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Precompute branch target into ALUOut.
        sig_o.alu_src_b = SRCB_IMM_SH;
        sig_o.alu_op    = ALUOP_MEM;
      end
      ST_MEM_ADDR: begin
        sig_o.alu_src_a = 1'b1;
        sig_o.alu_src_b = SRCB_IMM;
        sig_o.alu_op    = ALUOP_MEM;
      end
      ST_MEM_READ: begin
        sig_o.mem_read = 1'b1;
        sig_o.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        sig_o.reg_write  = 1'b1;
        sig_o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        sig_o.mem_write = 1'b1;
        sig_o.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        sig_o.alu_src_a = 1'b1;
        sig_o.alu_src_b = SRCB_REG;
        sig_o.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        sig_o.reg_write = 1'b1;
        sig_o.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        sig_o.alu_src_a     = 1'b1;
        sig_o.alu_src_b     = SRCB_REG;
        sig_o.alu_op        = ALUOP_BRANCH;
        sig_o.pc_write_cond = 1'b1;
        sig_o.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        sig_o.pc_write  = 1'b1;
        sig_o.pc_source = PCSRC_JUMP;
      end
`ifdef MAIN_CONTROL_ADDI_EN
      ST_ADDI_EXEC: begin
        sig_o.alu_src_a = 1'b1;
        sig_o.alu_src_b = SRCB_IMM;
        sig_o.alu_op    = ALUOP_MEM;
      end
      ST_ADDI_WB: begin
        sig_o.reg_write = 1'b1;
      end
`endif
      default: sig_o = '0;
    endcase
  end

endmodule

// File: rtl/main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles FETCH-to-FETCH.
// Backpressure: memReady_in low holds FETCH/MEM_READ/MEM_WRITE one cycle each.
// Ports: clock_in, reset_n_in (async active-low), opcode_in, memReady_in in;
//        datapath enables/selects, aluOp_out and illegal_out out.
// Optional: MAIN_CONTROL_ADDI_EN adds the addi path (ADDI_EXEC, ADDI_WB).
import mips_pkg::*;

module main_control (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic [5:0] opcode_in,
  input  logic       memReady_in,
  output logic       pcWrite_out,
  output logic       pcWriteCond_out,
  output logic       iorD_out,
  output logic       memRead_out,
  output logic       memWrite_out,
  output logic       memToReg_out,
  output logic       irWrite_out,
  output logic       regWrite_out,
  output logic       regDst_out,
  output logic       aluSrcA_out,
  output logic [1:0] aluSrcB_out,
  output logic [1:0] pcSource_out,
  output logic [1:0] aluOp_out,
  output logic       illegal_out
);

  ctrl_state_t state_q, state_d;
  ctrl_sig_t   sig;
  logic        ready_gated;

  // During reset the state already reads FETCH; masking ready keeps irWrite
  // and pcWrite low so nothing is committed while reset is held.
  assign ready_gated = memReady_in & reset_n_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:
        if (memReady_in) state_d = ST_DECODE;
      ST_DECODE: begin
        if ((opcode_in == OP_LW) || (opcode_in == OP_SW)) state_d = ST_MEM_ADDR;
        else if (opcode_in == OP_RTYPE)                   state_d = ST_EXECUTE;
        else if (opcode_in == OP_BEQ)                     state_d = ST_BRANCH;
        else if (opcode_in == OP_J)                       state_d = ST_JUMP;
`ifdef MAIN_CONTROL_ADDI_EN
        else if (opcode_in == OP_ADDI)                    state_d = ST_ADDI_EXEC;
`endif
        else                                              state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        if (opcode_in == OP_LW)      state_d = ST_MEM_READ;
        else if (opcode_in == OP_SW) state_d = ST_MEM_WRITE;
        else                         state_d = ST_FETCH;
      end
      ST_MEM_READ:
        if (memReady_in) state_d = ST_MEM_WB;
      ST_MEM_WRITE:
        if (memReady_in) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_MEM_WB,
      ST_R_WB,
      ST_BRANCH,
      ST_JUMP:      state_d = ST_FETCH;
`ifdef MAIN_CONTROL_ADDI_EN
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
`endif
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_FETCH;
    else             state_q <= state_d;
  end

  main_control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (ready_gated),
    .sig_o       (sig)
  );

  assign pcWrite_out     = sig.pc_write;
  assign pcWriteCond_out = sig.pc_write_cond;
  assign iorD_out        = sig.iord;
  assign memRead_out     = sig.mem_read;
  assign memWrite_out    = sig.mem_write;
  assign memToReg_out    = sig.mem_to_reg;
  assign irWrite_out     = sig.ir_write;
  assign regWrite_out    = sig.reg_write;
  assign regDst_out      = sig.reg_dst;
  assign aluSrcA_out     = sig.alu_src_a;
  assign aluSrcB_out     = sig.alu_src_b;
  assign pcSource_out    = sig.pc_source;
  assign aluOp_out       = sig.alu_op;

  // Unsupported opcode is flagged only while it is being decoded.
  assign illegal_out = (state_q == ST_DECODE) && !op_supported(opcode_in);

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control: per-cycle expected control vectors are
// queued when stimulus is driven and compared when the outputs are sampled.
module tb_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_write, reg_dst, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source, alu_op;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  // Bench-local state labels
  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MREAD = 3, S_MWB = 4,
                 S_MWRITE = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_AEXEC = 10, S_AWB = 11;

  main_control dut (
    .clock_in        (clk),
    .reset_n_in      (rst_n),
    .opcode_in       (opcode),
    .memReady_in     (mem_ready),
    .pcWrite_out     (pc_write),
    .pcWriteCond_out (pc_write_cond),
    .iorD_out        (iord),
    .memRead_out     (mem_read),
    .memWrite_out    (mem_write),
    .memToReg_out    (mem_to_reg),
    .irWrite_out     (ir_write),
    .regWrite_out    (reg_write),
    .regDst_out      (reg_dst),
    .aluSrcA_out     (alu_src_a),
    .aluSrcB_out     (alu_src_b),
    .pcSource_out    (pc_source),
    .aluOp_out       (alu_op),
    .illegal_out     (illegal)
  );

  always #5 clk = ~clk;

  // Expected outputs for a state, straight from the control table.
  // Layout: pcW pcWC iorD mRd mWr m2r irW rW rDst srcA | srcB | pcSrc | aluOp | ill
  function automatic logic [16:0] expect_of(input int st, input logic rdy, input logic ill);
    logic [9:0] b;
    logic [1:0] sb, ps, ao;
    b = '0; sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      S_FETCH:  begin b = {rdy, 2'b00, 1'b1, 2'b00, rdy, 3'b000}; sb = 2'b01; end
      S_DECODE: sb = 2'b11;
      S_MADDR:  begin b = 10'b0000000001; sb = 2'b10; end
      S_MREAD:  b = 10'b0011000000;
      S_MWB:    b = 10'b0000010100;
      S_MWRITE: b = 10'b0010100000;
      S_EXEC:   begin b = 10'b0000000001; ao = 2'b10; end
      S_RWB:    b = 10'b0000000110;
      S_BRANCH: begin b = 10'b0100000001; ps = 2'b01; ao = 2'b01; end
      S_JUMP:   begin b = 10'b1000000000; ps = 2'b10; end
      S_AEXEC:  begin b = 10'b0000000001; sb = 2'b10; end
      S_AWB:    b = 10'b0000000100;
      default:  b = '0;
    endcase
    return {b, sb, ps, ao, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
            reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op, illegal};
  endfunction

  task automatic push_exp(input int st, input logic rdy, input logic ill);
    exp_q.push_back(expect_of(st, rdy, ill));
  endtask

  task automatic compare(input string tag);
    logic [16:0] e, o;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      o = observed();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed=%05h expected=%05h", tag, o, e);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare on the falling edge.
  task automatic step(input string tag, input int st, input logic rdy,
                      input logic [5:0] op, input logic ill);
    mem_ready = rdy;
    opcode    = op;
    push_exp(st, rdy & rst_n, ill);
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b100011;
    #2;
    // Reset held: FETCH values with irWrite/pcWrite masked, whatever ready says.
    step("rst_rdy1", S_FETCH, 1'b1, 6'b100011, 1'b0);
    step("rst_rdy0", S_FETCH, 1'b0, 6'b100011, 1'b0);
    rst_n = 1'b1;

    // lw, no waits: 5 cycles
    step("lw_fetch", S_FETCH,  1'b1, 6'b100011, 1'b0);
    step("lw_dec",   S_DECODE, 1'b1, 6'b100011, 1'b0);
    step("lw_addr",  S_MADDR,  1'b1, 6'b100011, 1'b0);
    step("lw_read",  S_MREAD,  1'b1, 6'b100011, 1'b0);
    step("lw_wb",    S_MWB,    1'b1, 6'b100011, 1'b0);

    // R-type with 3 FETCH wait states; ready low elsewhere must be ignored
    step("r_fw0",   S_FETCH,  1'b0, 6'b000000, 1'b0);
    step("r_fw1",   S_FETCH,  1'b0, 6'b000000, 1'b0);
    step("r_fw2",   S_FETCH,  1'b0, 6'b000000, 1'b0);
    step("r_fetch", S_FETCH,  1'b1, 6'b000000, 1'b0);
    step("r_dec",   S_DECODE, 1'b0, 6'b000000, 1'b0);
    step("r_exec",  S_EXEC,   1'b0, 6'b000000, 1'b0);
    step("r_wb",    S_RWB,    1'b0, 6'b000000, 1'b0);

    // sw with 2 wait states in MEM_WRITE
    step("sw_fetch", S_FETCH,  1'b1, 6'b101011, 1'b0);
    step("sw_dec",   S_DECODE, 1'b0, 6'b101011, 1'b0);
    step("sw_addr",  S_MADDR,  1'b0, 6'b101011, 1'b0);
    step("sw_w0",    S_MWRITE, 1'b0, 6'b101011, 1'b0);
    step("sw_w1",    S_MWRITE, 1'b0, 6'b101011, 1'b0);
    step("sw_w2",    S_MWRITE, 1'b1, 6'b101011, 1'b0);

    // beq then j
    step("beq_fetch", S_FETCH,  1'b1, 6'b000100, 1'b0);
    step("beq_dec",   S_DECODE, 1'b1, 6'b000100, 1'b0);
    step("beq_br",    S_BRANCH, 1'b1, 6'b000100, 1'b0);
    step("j_fetch",   S_FETCH,  1'b1, 6'b000010, 1'b0);
    step("j_dec",     S_DECODE, 1'b1, 6'b000010, 1'b0);
    step("j_jump",    S_JUMP,   1'b1, 6'b000010, 1'b0);

    // Illegal opcode: pulse in DECODE only, then straight back to FETCH
    step("ill_fetch", S_FETCH,  1'b1, 6'b111111, 1'b0);
    step("ill_dec",   S_DECODE, 1'b1, 6'b111111, 1'b1);

    // addi: legal path with the macro, illegal otherwise
    step("addi_fetch", S_FETCH, 1'b1, 6'b001000, 1'b0);
`ifdef MAIN_CONTROL_ADDI_EN
    step("addi_dec",  S_DECODE, 1'b1, 6'b001000, 1'b0);
    step("addi_exec", S_AEXEC,  1'b1, 6'b001000, 1'b0);
    step("addi_wb",   S_AWB,    1'b1, 6'b001000, 1'b0);
`else
    step("addi_dec",  S_DECODE, 1'b1, 6'b001000, 1'b1);
`endif

    // lw interrupted by reset in MEM_READ
    step("lr_fetch", S_FETCH,  1'b1, 6'b100011, 1'b0);
    step("lr_dec",   S_DECODE, 1'b1, 6'b100011, 1'b0);
    step("lr_addr",  S_MADDR,  1'b1, 6'b100011, 1'b0);
    step("lr_rd0",   S_MREAD,  1'b0, 6'b100011, 1'b0);
    mem_ready = 1'b1;
    push_exp(S_MREAD, 1'b1, 1'b0);
    #1;
    compare("lr_rd1_pre");
    rst_n = 1'b0;
    push_exp(S_FETCH, 1'b0, 1'b0);
    #1;
    compare("lr_rst_now");
    @(posedge clk);
    #1;
    step("lr_rst_hold", S_FETCH, 1'b1, 6'b100011, 1'b0);
    rst_n = 1'b1;

    // After release the first cycle is FETCH, then a clean jump
    step("post_fetch", S_FETCH,  1'b1, 6'b000010, 1'b0);
    step("post_dec",   S_DECODE, 1'b1, 6'b000010, 1'b0);
    step("post_jump",  S_JUMP,   1'b1, 6'b000010, 1'b0);
    step("post_back",  S_FETCH,  1'b0, 6'b000010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
